// File: rtl/sync_dp_ram_init.sv
// Simple dual-port RAM with one write port and one read port on one clock.
// It has byte-lane write enables and a selectable read-during-write result.
// An optional output register adds a cycle of read latency.
// A sequential sweep writes zero to every word. The sweep runs after reset
// release, and again whenever clear is sampled high.
// DATA_W must be a multiple of 8.
module sync_dp_ram_init #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                write,
    input  logic [ADDR_W-1:0]   write_address,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic                read,
    input  logic [ADDR_W-1:0]   read_address,
    output logic [DATA_W-1:0]   data_out,
    output logic                read_valid,
    output logic                init_busy
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int LANES = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {INIT, RUN} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   ptr_reg, ptr_next;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                sweep;
    logic                run_access;
    logic                wr_fire;
    logic                rd_fire;
    logic                same_addr;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [LANES-1:0]    lane_we;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   rd_merged;

    logic [DATA_W-1:0]   s1_data_reg;
    logic                s1_valid_reg;

    // FSM state and sweep pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= INIT;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Next state: the sweep advances one word per cycle, and clear restarts it.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            INIT: begin
                if (clear) begin
                    ptr_next = '0;
                end else begin
                    ptr_next = ptr_reg + 1'b1;
                    if (ptr_reg == LAST_ADDR) begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (clear) begin
                    state_next = INIT;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = INIT;
                ptr_next   = '0;
            end
        endcase
    end

    // User accesses happen only in RUN. They are also blocked on the edge that samples clear.
    assign sweep      = (state_reg == INIT);
    assign run_access = (state_reg == RUN) && !clear;
    assign wr_fire    = run_access && write;
    assign rd_fire    = run_access && read;
    assign same_addr  = (write_address == read_address);
    assign init_busy  = sweep;

    // The single write port is shared. The sweep drives it in INIT, and user writes drive it in RUN.
    assign mem_waddr = sweep ? ptr_reg : write_address;
    assign mem_wdata = sweep ? '0 : data_in;
    assign rd_word   = mem[read_address];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_we[gi] = sweep || (wr_fire && byte_en[gi]);
            // In new-data mode, each enabled lane of a same-address write is forwarded to the read.
            assign rd_merged[8*gi +: 8] =
                ((RDW_MODE != 0) && wr_fire && same_addr && byte_en[gi])
                    ? data_in[8*gi +: 8] : rd_word[8*gi +: 8];
        end
    endgenerate

    // Memory array write with per-lane enables.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (lane_we[k]) begin
                mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
        end
    end

    // First read stage. Data updates only when a read fires, so it holds between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_data_reg  <= '0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= rd_fire;
            if (rd_fire) begin
                s1_data_reg <= rd_merged;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] s2_data_reg;
            logic              s2_valid_reg;

            // Optional output register. It advances only when stage one holds a new result.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    s2_data_reg  <= '0;
                    s2_valid_reg <= 1'b0;
                end else begin
                    s2_valid_reg <= s1_valid_reg;
                    if (s1_valid_reg) begin
                        s2_data_reg <= s1_data_reg;
                    end
                end
            end

            assign data_out   = s2_data_reg;
            assign read_valid = s2_valid_reg;
        end else begin : g_no_out_reg
            assign data_out   = s1_data_reg;
            assign read_valid = s1_valid_reg;
        end
    endgenerate

endmodule
